// File: rtl/chess_countdown.sv
// Two-player chess clock countdown engine: 1 s prescaler, per-player mm:ss
// countdown, start/pause/turn control and sticky out-of-time flags.
module chess_countdown #(
  parameter int TICK_DIV = 100000000,
  parameter int PRE_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] min_in,
  input  logic       load,
  input  logic       start_pause,
  input  logic       turn_sw,
  output logic [5:0] p0_min,
  output logic [5:0] p0_sec,
  output logic [5:0] p1_min,
  output logic [5:0] p1_sec,
  output logic       active,
  output logic       running,
  output logic       flag0,
  output logic       flag1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO  = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [5:0]       MAX_MIN   = 6'd59;
  localparam logic [11:0]      RST_TIME  = {6'd5, 6'd0};

  // One-second decrement of a packed {min, sec}; saturates at 00:00.
  function automatic logic [11:0] dec_time(input logic [11:0] t);
    logic [11:0] r;
    if (t[5:0] != 6'd0) begin
      r = {t[11:6], t[5:0] - 6'd1};
    end else if (t[11:6] != 6'd0) begin
      r = {t[11:6] - 6'd1, 6'd59};
    end else begin
      r = 12'd0;
    end
    return r;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [PRE_W-1:0] pre_r, pre_s;
  logic [11:0]      p0_r, p0_s, p1_r, p1_s;
  logic             active_r, active_s;
  logic             running_r;
  logic             flag0_r, flag0_s, flag1_r, flag1_s;

  logic [5:0]  load_min_s;
  logic [11:0] cur_time_s, dec_s;
  logic        tick_s, times_ok_s;

  assign load_min_s = (min_in > MAX_MIN) ? MAX_MIN : min_in;
  assign tick_s     = (state_r == S_RUN) && (pre_r == TICK_LAST);
  assign cur_time_s = active_r ? p1_r : p0_r;
  assign dec_s      = dec_time(cur_time_s);
  assign times_ok_s = (p0_r != 12'd0) && (p1_r != 12'd0);

  // Next-state, prescaler, time and flag update logic.
  always_comb begin
    state_s  = state_r;
    pre_s    = pre_r;
    p0_s     = p0_r;
    p1_s     = p1_r;
    active_s = active_r;
    flag0_s  = flag0_r;
    flag1_s  = flag1_r;
    case (state_r)
      S_IDLE: begin
        if (load) begin
          p0_s    = {load_min_s, 6'd0};
          p1_s    = {load_min_s, 6'd0};
          flag0_s = 1'b0;
          flag1_s = 1'b0;
          pre_s   = PRE_ZERO;
        end else begin
          if (turn_sw) begin
            active_s = ~active_r;
          end else begin
            active_s = active_r;
          end
          if (start_pause && times_ok_s) begin
            state_s = S_RUN;
            pre_s   = PRE_ZERO;
          end else begin
            state_s = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (tick_s) begin
          pre_s = PRE_ZERO;
          if (active_r) begin
            p1_s = dec_s;
          end else begin
            p0_s = dec_s;
          end
          // Reaching 00:00 wins over any switch or pause in the same cycle.
          if (dec_s == 12'd0) begin
            state_s = S_DONE;
            if (active_r) begin
              flag1_s = 1'b1;
            end else begin
              flag0_s = 1'b1;
            end
          end else begin
            if (turn_sw) begin
              active_s = ~active_r;
            end else begin
              active_s = active_r;
            end
            if (start_pause) begin
              state_s = S_PAUSE;
            end else begin
              state_s = S_RUN;
            end
          end
        end else begin
          if (turn_sw) begin
            active_s = ~active_r;
            pre_s    = PRE_ZERO;
          end else begin
            pre_s    = pre_r + PRE_ONE;
          end
          if (start_pause) begin
            state_s = S_PAUSE;
          end else begin
            state_s = S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (load) begin
          p0_s    = {load_min_s, 6'd0};
          p1_s    = {load_min_s, 6'd0};
          flag0_s = 1'b0;
          flag1_s = 1'b0;
          pre_s   = PRE_ZERO;
          state_s = S_IDLE;
        end else if (start_pause) begin
          state_s = S_RUN;
        end else begin
          state_s = S_PAUSE;
        end
      end
      S_DONE: begin
        if (load) begin
          p0_s    = {load_min_s, 6'd0};
          p1_s    = {load_min_s, 6'd0};
          flag0_s = 1'b0;
          flag1_s = 1'b0;
          pre_s   = PRE_ZERO;
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        pre_s   = PRE_ZERO;
      end
    endcase
  end

  // State and datapath registers; running is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      pre_r     <= PRE_ZERO;
      p0_r      <= RST_TIME;
      p1_r      <= RST_TIME;
      active_r  <= 1'b0;
      running_r <= 1'b0;
      flag0_r   <= 1'b0;
      flag1_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      pre_r     <= pre_s;
      p0_r      <= p0_s;
      p1_r      <= p1_s;
      active_r  <= active_s;
      running_r <= (state_s == S_RUN);
      flag0_r   <= flag0_s;
      flag1_r   <= flag1_s;
    end
  end

  assign p0_min  = p0_r[11:6];
  assign p0_sec  = p0_r[5:0];
  assign p1_min  = p1_r[11:6];
  assign p1_sec  = p1_r[5:0];
  assign active  = active_r;
  assign running = running_r;
  assign flag0   = flag0_r;
  assign flag1   = flag1_r;

endmodule

// File: tb/tb_chess_countdown.sv
// Scoreboard bench for chess_countdown: directed pulses push hand-computed
// expected output snapshots tagged with a cycle; a monitor pops and compares.
module tb_chess_countdown;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] min_in;
  logic       load, start_pause, turn_sw;
  logic [5:0] p0_min, p0_sec, p1_min, p1_sec;
  logic       active, running, flag0, flag1;

  chess_countdown #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .min_in(min_in), .load(load),
    .start_pause(start_pause), .turn_sw(turn_sw),
    .p0_min(p0_min), .p0_sec(p0_sec), .p1_min(p1_min), .p1_sec(p1_sec),
    .active(active), .running(running), .flag0(flag0), .flag1(flag1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [27:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   npass = 0;
  int   ntotal = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: output snapshot is presented every cycle; compare due entries.
  initial begin
    exp_t        e;
    logic [27:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        got = {p0_min, p0_sec, p1_min, p1_sec, active, running, flag0, flag1};
        ntotal = ntotal + 1;
        if (got === e.v) begin
          npass = npass + 1;
        end else begin
          $display("FAIL %s @cyc %0d: got p0=%0d:%0d p1=%0d:%0d act/run/f0/f1=%b, expected p0=%0d:%0d p1=%0d:%0d act/run/f0/f1=%b",
                   e.name, cyc, got[27:22], got[21:16], got[15:10], got[9:4], got[3:0],
                   e.v[27:22], e.v[21:16], e.v[15:10], e.v[9:4], e.v[3:0]);
        end
      end
    end
  end

  task automatic expect_at(input string name, input int ofs,
                           input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] c, input logic [5:0] d,
                           input logic act, input logic run,
                           input logic f0, input logic f1);
    exp_t e;
    e.cyc  = cyc + ofs;
    e.v    = {a, b, c, d, act, run, f0, f1};
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic ld, input logic sp, input logic ts, input logic [5:0] m);
    min_in      = m;
    load        = ld;
    start_pause = sp;
    turn_sw     = ts;
    @(negedge clk);
    load        = 1'b0;
    start_pause = 1'b0;
    turn_sw     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; min_in = 6'd0; load = 1'b0; start_pause = 1'b0; turn_sw = 1'b0;
    step(2);
    expect_at("reset_held", 1, 6'd5, 6'd0, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    expect_at("reset_values", 2, 6'd5, 6'd0, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    expect_at("load_2", 1, 6'd2, 6'd0, 6'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd2);

    // Basic countdown and turn switch with a full second for the new player.
    expect_at("load_1", 1, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd1);
    expect_at("start", 1, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("pre_partial", 3, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at("p0_0059", 4, 6'd0, 6'd59, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4);
    expect_at("p0_0058", 4, 6'd0, 6'd58, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4);
    step(2);
    expect_at("turn_sw", 1, 6'd0, 6'd58, 6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 6'd0);
    expect_at("switch_full_sec", 3, 6'd0, 6'd58, 6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_at("p1_0059", 4, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4);

    // Load ignored in RUN; pause keeps the partial second.
    expect_at("load_in_run", 1, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd10);
    expect_at("pause", 1, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("pause_turn_ign", 1, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 6'd0);
    expect_at("pause_hold", 20, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b0, 1'b0, 1'b0);
    step(20);
    expect_at("resume", 1, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("resume_partial", 1, 6'd0, 6'd58, 6'd0, 6'd59, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_at("resume_tick", 2, 6'd0, 6'd58, 6'd0, 6'd58, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2);

    // Tick and pause together: decrement, then PAUSE.
    step(3);
    expect_at("tick_pause", 1, 6'd0, 6'd58, 6'd0, 6'd57, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("load_63", 1, 6'd59, 6'd0, 6'd59, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd63);
    expect_at("idle_turn", 1, 6'd59, 6'd0, 6'd59, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 6'd0);
    expect_at("load_beats_start", 1, 6'd4, 6'd0, 6'd4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0, 6'd4);
    expect_at("load_0", 1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd0);
    expect_at("start_zero", 1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("still_idle", 3, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);

    // Run player 0 out of time; DONE is frozen until load.
    expect_at("load_1b", 1, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd1);
    expect_at("start_b", 1, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("p0_0001", 236, 6'd0, 6'd1, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at("flag0", 240, 6'd0, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(240);
    expect_at("done_start_ign", 1, 6'd0, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("done_turn_ign", 1, 6'd0, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 6'd0);
    expect_at("done_hold", 8, 6'd0, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8);
    expect_at("load_3", 1, 6'd3, 6'd0, 6'd3, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd3);

    // turn_sw on the final tick: flag wins, switch dropped.
    expect_at("load_1c", 1, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd1);
    expect_at("start_c", 1, 6'd1, 6'd0, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("p0_0001c", 236, 6'd0, 6'd1, 6'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(239);
    expect_at("tick_turn", 1, 6'd0, 6'd0, 6'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 6'd0);

    // Asynchronous reset in the middle of a run.
    expect_at("load_2b", 1, 6'd2, 6'd0, 6'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd2);
    expect_at("turn_idle_b", 1, 6'd2, 6'd0, 6'd2, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 6'd0);
    expect_at("start_d", 1, 6'd2, 6'd0, 6'd2, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 6'd0);
    expect_at("p1_0159", 4, 6'd2, 6'd0, 6'd1, 6'd59, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_at("async_reset", 0, 6'd5, 6'd0, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    expect_at("post_reset", 2, 6'd5, 6'd0, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);

    for (int i = 0; i < 50 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
      ntotal = ntotal + q.size();
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
